// File: rtl/hamming_rx_controller.sv
// Receive-side Hamming(12,8) controller: captures codewords, computes the syndrome,
// corrects single-bit errors in a 2-stage valid/ready pipeline, and keeps saturating error counters.
module hamming_rx_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic [3:0]       out_syn,
  output logic             out_corr,
  output logic             out_uncorr,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  logic        s1_valid;
  logic [11:0] s1_code;
  logic        s2_valid;
  logic        s1_adv;
  logic        s2_adv;
  logic        deliver;
  logic [3:0]  syn;
  logic [7:0]  raw_data;
  logic [7:0]  fix_data;
  logic        fix_corr;
  logic        fix_uncorr;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = s1_valid & s2_adv;
  assign in_ready  = ~s1_valid | s2_adv;
  assign out_valid = s2_valid;
  assign deliver   = s2_valid & out_ready;

  // Stage 1: capture. When in_ready is high, stage 1 is either empty or handing
  // its word to stage 2 this cycle, so it simply takes whatever in_valid says.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and same-cycle stage hand-offs do not race.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_code <= in_code;
    end
  end

  // Position k of the codeword lives in s1_code[k-1].
  assign syn[0] = s1_code[0] ^ s1_code[2] ^ s1_code[4] ^ s1_code[6] ^ s1_code[8]  ^ s1_code[10];
  assign syn[1] = s1_code[1] ^ s1_code[2] ^ s1_code[5] ^ s1_code[6] ^ s1_code[9]  ^ s1_code[10];
  assign syn[2] = s1_code[3] ^ s1_code[4] ^ s1_code[5] ^ s1_code[6] ^ s1_code[11];
  assign syn[3] = s1_code[7] ^ s1_code[8] ^ s1_code[9] ^ s1_code[10] ^ s1_code[11];

  assign raw_data = {s1_code[11], s1_code[10], s1_code[9], s1_code[8],
                     s1_code[6],  s1_code[5],  s1_code[4], s1_code[2]};

  // Syndrome-to-data-bit correction map; parity-bit hits leave data untouched.
  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    fix_data   = raw_data;
    fix_corr   = 1'b0;
    fix_uncorr = 1'b0;
    case (syn)
      4'd0:                    ;
      4'd1, 4'd2, 4'd4, 4'd8:  fix_corr = 1'b1;
      4'd3:  begin fix_data[0] = ~raw_data[0]; fix_corr = 1'b1; end
      4'd5:  begin fix_data[1] = ~raw_data[1]; fix_corr = 1'b1; end
      4'd6:  begin fix_data[2] = ~raw_data[2]; fix_corr = 1'b1; end
      4'd7:  begin fix_data[3] = ~raw_data[3]; fix_corr = 1'b1; end
      4'd9:  begin fix_data[4] = ~raw_data[4]; fix_corr = 1'b1; end
      4'd10: begin fix_data[5] = ~raw_data[5]; fix_corr = 1'b1; end
      4'd11: begin fix_data[6] = ~raw_data[6]; fix_corr = 1'b1; end
      4'd12: begin fix_data[7] = ~raw_data[7]; fix_corr = 1'b1; end
      default:                 fix_uncorr = 1'b1;
    endcase
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_data   <= '0;
      out_syn    <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_adv) begin
        out_data   <= fix_data;
        out_syn    <= syn;
        out_corr   <= fix_corr;
        out_uncorr <= fix_uncorr;
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (deliver) begin
      if (out_corr && (corr_cnt != '1))     corr_cnt   <= corr_cnt + 1'b1;
      if (out_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_rx_controller.sv
// Directed bench for hamming_rx_controller: table of hand-decoded codewords,
// then backpressure, counter saturation/clear, and mid-stream reset sequences.
module tb_hamming_rx_controller;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [11:0]      in_code;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_data;
  logic [3:0]       out_syn;
  logic             out_corr;
  logic             out_uncorr;
  logic             out_valid;
  logic             out_ready;
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  hamming_rx_controller #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_syn    (out_syn),
    .out_corr   (out_corr),
    .out_uncorr (out_uncorr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] code;
    logic [7:0]  data;
    logic [3:0]  syn;
    logic        corr;
    logic        uncorr;
  } vec_t;

  vec_t vecs [12];
  int   checks = 0;
  int   errors = 0;

  // out_ready pattern for the backpressure run; includes a run of three stalls.
  logic pat [16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         tx;
    int         rx;
    bit         have_hold;
    logic [7:0] hold_data;
    logic [3:0] hold_syn;

    vecs[0]  = '{12'hA27, 8'hA5, 4'd0,  1'b0, 1'b0};
    vecs[1]  = '{12'hA07, 8'hA5, 4'd6,  1'b1, 1'b0};
    vecs[2]  = '{12'hAA7, 8'hA5, 4'd8,  1'b1, 1'b0};
    vecs[3]  = '{12'h226, 8'h25, 4'd13, 1'b0, 1'b1};
    vecs[4]  = '{12'hA23, 8'hA5, 4'd3,  1'b1, 1'b0};
    vecs[5]  = '{12'h227, 8'hA5, 4'd12, 1'b1, 1'b0};
    vecs[6]  = '{12'hA26, 8'hA5, 4'd1,  1'b1, 1'b0};
    vecs[7]  = '{12'h225, 8'h25, 4'd14, 1'b0, 1'b1};
    vecs[8]  = '{12'h223, 8'h24, 4'd15, 1'b0, 1'b1};
    vecs[9]  = '{12'hF77, 8'hFF, 4'd0,  1'b0, 1'b0};
    vecs[10] = '{12'hD77, 8'hFF, 4'd10, 1'b1, 1'b0};
    vecs[11] = '{12'hF37, 8'hFF, 4'd7,  1'b1, 1'b0};

    rst = 1'b1; in_code = '0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_syn",   32'(out_syn),   32'd0);
    check("rst_out_flags", 32'({out_corr, out_uncorr}), 32'd0);
    check("rst_counters",  32'({corr_cnt, uncorr_cnt}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // One word at a time: fixed 2-cycle latency and per-word counter effect.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); cnt_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk); cnt_clr = 1'b0; in_code = vecs[i].code; in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      check($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_valid", i),  32'(out_valid),  32'd1);
      check($sformatf("v%0d_data", i),   32'(out_data),   32'(vecs[i].data));
      check($sformatf("v%0d_syn", i),    32'(out_syn),    32'(vecs[i].syn));
      check($sformatf("v%0d_corr", i),   32'(out_corr),   32'(vecs[i].corr));
      check($sformatf("v%0d_uncorr", i), 32'(out_uncorr), 32'(vecs[i].uncorr));
      @(negedge clk);
      check($sformatf("v%0d_corr_cnt", i),   32'(corr_cnt),   32'(vecs[i].corr));
      check($sformatf("v%0d_uncorr_cnt", i), 32'(uncorr_cnt), 32'(vecs[i].uncorr));
      check($sformatf("v%0d_drained", i),    32'(out_valid),  32'd0);
    end

    // Backpressure: six words back-to-back against a stalling consumer.
    tx = 0; rx = 0; have_hold = 1'b0; hold_data = '0; hold_syn = '0;
    for (int cyc = 0; cyc < 60 && rx < 6; cyc++) begin
      @(negedge clk);
      if (have_hold) begin
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        check("bp_stall_data",  32'(out_data),  32'(hold_data));
        check("bp_stall_syn",   32'(out_syn),   32'(hold_syn));
      end
      out_ready = (cyc < 16) ? pat[cyc] : 1'b1;
      in_valid  = (tx < 6);
      in_code   = vecs[(tx < 6) ? tx : 0].code;
      #1;
      check("bp_in_ready", 32'(in_ready), 32'(!((tx - rx) == 2 && !out_ready)));
      have_hold = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          check($sformatf("bp_w%0d_data", rx), 32'(out_data), 32'(vecs[rx].data));
          check($sformatf("bp_w%0d_syn", rx),  32'(out_syn),  32'(vecs[rx].syn));
          rx++;
        end else begin
          have_hold = 1'b1;
          hold_data = out_data;
          hold_syn  = out_syn;
        end
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    check("bp_delivered", 32'(rx), 32'd6);

    // Saturation with CNT_W=2: five corrected words leave the counter at 3.
    @(negedge clk); cnt_clr = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk); cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = 12'hA07;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_corr_cnt",   32'(corr_cnt),   32'd3);
    check("sat_uncorr_cnt", 32'(uncorr_cnt), 32'd0);

    // Clear coincident with a corrected delivery: clear wins.
    in_valid = 1'b1; in_code = 12'hA07;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("clr_word_valid", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    check("clr_corr_cnt", 32'(corr_cnt),  32'd0);
    check("clr_drained",  32'(out_valid), 32'd0);

    in_valid = 1'b1; in_code = 12'hA07;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("post_clr_corr_cnt", 32'(corr_cnt), 32'd1);

    // Reset with two words in flight and the consumer stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 12'hA27;
    @(negedge clk); in_code = 12'h226;
    @(negedge clk); in_valid = 1'b0;
    #1;
    check("mid_full_valid",    32'(out_valid), 32'd1);
    check("mid_full_in_ready", 32'(in_ready),  32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    check("mid_rst_corr_cnt",  32'(corr_cnt),  32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle%0d", i), 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_rx_controller.md
Name: hamming_rx_controller

Overview:
- Streaming receive-side controller for the Hamming(12,8) link. It accepts 12-bit codewords over a valid/ready handshake and computes the 4-bit syndrome.
- It sequences correction through a 2-stage pipeline, emits 8-bit data with status flags, and keeps saturating statistics counters.
- It sits between the channel/deserializer and the data consumer. It owns the syndrome-to-data-bit correction mapping.

Parameters:
- CNT_W, 16, width of the corrected-word and uncorrectable-word counters (>=2).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_code  input  12  codeword; bit k (1..12, bit 1 = LSB) = Hamming position k
- in_valid  input  1  in_code valid
- in_ready  output  1  controller accepts in_code this cycle
- out_data  output  8  corrected data; bit 1 = LSB
- out_syn  output  4  syndrome of the word on out_data
- out_corr  output  1  single-bit error found and corrected (syndrome 1..12)
- out_uncorr  output  1  invalid syndrome 13..15; data passed uncorrected
- out_valid  output  1  out_* valid
- out_ready  input  1  consumer accepts out_*
- cnt_clr  input  1  synchronous clear of both counters
- corr_cnt  output  CNT_W  saturating count of delivered words with out_corr=1
- uncorr_cnt  output  CNT_W  saturating count of delivered words with out_uncorr=1

Behaviour:
- Reset (async, rst=1):
  - s1_valid, s2_valid, out_valid, out_corr and out_uncorr are 0.
  - out_data, out_syn, corr_cnt and uncorr_cnt are 0.
  - in_ready is 1 as soon as reset deasserts.
  - Reset mid-stream discards all in-flight words; no partial output.
- Code layout:
  - Parity bits sit at positions 1, 2, 4 and 8.
  - Data bits map as data[1..8] = positions 3, 5, 6, 7, 9, 10, 11, 12.
- Stage 1 (capture): on in_valid & in_ready, register in_code and compute the syndrome combinationally from the registered word:
  - C[1] = xor of positions 1,3,5,7,9,11
  - C[2] = xor of positions 2,3,6,7,10,11
  - C[3] = xor of positions 4,5,6,7,12
  - C[4] = xor of positions 8,9,10,11,12
- Stage 2 (correct): on advance, register the extracted data, the syndrome and the flags.
  - Syndrome 0: data unchanged, corr=0, uncorr=0.
  - Syndrome 1, 2, 4 or 8: parity-bit error; data unchanged, corr=1.
  - Syndrome 3, 5, 6, 7, 9, 10, 11, 12: flip data bit 1..8 respectively; corr=1.
  - Syndrome 13..15: data unchanged, corr=0, uncorr=1.
- Handshake / pipelining:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = ~s1_valid | s2_adv.
  - out_valid = s2_valid. out_* are held stable while out_valid & ~out_ready.
  - Latency: 2 cycles from input acceptance to out_valid.
  - Throughput is 1 word/cycle with out_ready held at 1. No bubbles, no drops, no duplicates under any out_ready pattern.
  - Stage 1 and stage 2 update in the same cycle when both advance; simultaneous accept and deliver is allowed.
- Counters:
  - A counter increments by 1 on out_valid & out_ready when the matching flag is set.
  - Each counter saturates at 2^CNT_W-1 and holds there.
  - cnt_clr has priority over a same-cycle increment (result 0).
  - Counters are unaffected by stalls.
- in_valid may drop at any time without a handshake. The controller ignores in_code when in_valid=0.

Test Plan:
- Clean word: in_code=12'hA27, out_ready=1 -> 2 cycles later out_data=8'hA5, out_syn=0, corr=0, uncorr=0; counters stay 0.
- Data-bit error at position 6: in_code=12'hA07 -> out_data=8'hA5, out_syn=4'd6, out_corr=1; corr_cnt=1.
- Parity-bit error at position 8: in_code=12'hAA7 -> out_data=8'hA5, out_syn=4'd8, out_corr=1.
- Double error at positions 12 and 1: in_code=12'h226 -> out_syn=4'd13, out_uncorr=1, out_data=8'h25 (uncorrected); uncorr_cnt=1.
- Backpressure: stream 6 words back-to-back, out_ready toggling randomly, including 3 consecutive 0s -> in_ready=0 only while both stages are full. All 6 words arrive in order, unaltered. out_* stay stable during stalls.
- Saturation and reset: CNT_W=2, deliver 5 corrected words -> corr_cnt=3. Then cnt_clr coincident with a corrected delivery -> corr_cnt=0. Then rst asserted with 2 words in flight -> out_valid=0 immediately and no stale output after release.
